// File: rtl/bcd8_to_bin_pkg.sv
// Shared constants for the 8-digit BCD-to-binary converter: sizes, FSM encoding,
// and a digit-range check used at capture time.
package bcd8_to_bin_pkg;

    localparam int NDIG    = 8;
    localparam int W       = 4 * NDIG;
    localparam int NSTEP   = W;
    localparam int DIG_MAX = 9;
    localparam int CNT_W   = 6;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] FIN   = 2'd2;

    function automatic logic any_bad_digit(input logic [W-1:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++)
            if (int'(bcd[4*i +: 4]) > DIG_MAX) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/bcd8_to_bin_nibble_adj.sv
// Per-digit correction for reverse double-dabble: a nibble that reached 8 or more
// after the right shift carried a half-ten from above and gets 3 taken off.
module bcd_nibble_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd8) ? din - 4'd3 : din;

endmodule

// File: rtl/bcd8_to_bin.sv
// Sequential 8-digit BCD to 32-bit two's-complement converter, one reverse
// double-dabble step per clock with a start/busy/done handshake.
import bcd8_to_bin_pkg::*;

module bcd8_to_bin (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   d1,
    input  logic [3:0]   d2,
    input  logic [3:0]   d3,
    input  logic [3:0]   d4,
    input  logic [3:0]   d5,
    input  logic [3:0]   d6,
    input  logic [3:0]   d7,
    input  logic [3:0]   d8,
    input  logic         neg,
    output logic [W-1:0] numero,
    output logic         busy,
    output logic         done,
    output logic         err
);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     bcd_sr, bin_sr;
    logic [W-1:0]     bcd_shf, bcd_nxt, cap;
    logic             neg_r, err_r;

    assign cap     = {d8, d7, d6, d5, d4, d3, d2, d1};
    assign bcd_shf = bcd_sr >> 1;
    assign busy    = (state != IDLE);

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_nibble_adj u_adj (
            .din  (bcd_shf[4*g +: 4]),
            .dout (bcd_nxt[4*g +: 4])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            bcd_sr <= '0;
            bin_sr <= '0;
            neg_r  <= 1'b0;
            err_r  <= 1'b0;
            numero <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        bcd_sr <= cap;
                        bin_sr <= '0;
                        neg_r  <= neg;
                        cnt    <= '0;
                        // Bad digits skip the shift phase entirely
                        if (any_bad_digit(cap)) begin
                            err_r <= 1'b1;
                            state <= FIN;
                        end else begin
                            err_r <= 1'b0;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    bcd_sr <= bcd_nxt;
                    bin_sr <= {bcd_sr[0], bin_sr[W-1:1]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(NSTEP - 1)) state <= FIN;
                end
                FIN: begin
                    numero <= err_r ? '0 : (neg_r ? ~bin_sr + W'(1) : bin_sr);
                    err    <= err_r;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Every BCD bit has migrated into bin_sr once all steps are done
    always @(posedge clock)
        if (!reset && state == FIN && !err_r) assert (bcd_sr == '0);

endmodule

// File: tb/tb_bcd8_to_bin.sv
// Self-checking bench for bcd8_to_bin: directed table, handshake corner cases,
// and random conversions compared against a decimal-arithmetic reference.
module tb_bcd8_to_bin;

    logic        clock = 1'b0;
    logic        reset, start, neg;
    logic [3:0]  dv [8];
    logic [31:0] numero;
    logic        busy, done, err;

    int n_chk  = 0;
    int n_fail = 0;

    bcd8_to_bin dut (
        .clock (clock), .reset (reset), .start (start),
        .d1 (dv[0]), .d2 (dv[1]), .d3 (dv[2]), .d4 (dv[3]),
        .d5 (dv[4]), .d6 (dv[5]), .d7 (dv[6]), .d8 (dv[7]),
        .neg (neg), .numero (numero), .busy (busy), .done (done), .err (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] bcd;
        bit          sgn;
        logic [31:0] exp_num;
        bit          exp_err;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain decimal value of the digits, then sign.
    task automatic model(input logic [31:0] bcd, input bit sgn,
                         output logic [31:0] num, output bit e);
        int unsigned mag;
        mag = 0;
        e   = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            logic [3:0] nib;
            nib = bcd[4*i +: 4];
            if (nib > 4'd9) e = 1'b1;
            mag = mag * 10 + nib;
        end
        num = e ? 32'd0 : (sgn ? 32'(-mag) : 32'(mag));
    endtask

    // Called from a negedge; returns just after E0.
    task automatic launch(input logic [31:0] bcd, input bit sgn);
        for (int i = 0; i < 8; i++) dv[i] = bcd[4*i +: 4];
        neg   = sgn;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        repeat (60) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    // Full conversion with latency check; leaves the bench on the negedge where done is high.
    task automatic convert(input string name, input logic [31:0] bcd, input bit sgn,
                           input logic [31:0] exp_num, input bit exp_err, input int lat);
        int cyc;
        bit ok;
        launch(bcd, sgn);
        @(negedge clock);
        chk({name, " busy"}, 32'(busy), 32'd1);
        wait_done(cyc, ok);
        chk({name, " done seen"}, 32'(ok), 32'd1);
        chk({name, " latency"}, 32'(cyc), 32'(lat));
        chk({name, " numero"}, numero, exp_num);
        chk({name, " err"}, 32'(err), 32'(exp_err));
        chk({name, " busy at done"}, 32'(busy), 32'd0);
    endtask

    vec_t vecs [8];

    initial begin
        logic [31:0] enum_, bcd;
        bit          eerr, sgn;
        int          cyc, dcount;
        bit          ok;

        vecs[0] = '{32'h12345678, 1'b0, 32'h00BC614E, 1'b0, 33};
        vecs[1] = '{32'h99999999, 1'b1, 32'hFA0A1F01, 1'b0, 33};
        vecs[2] = '{32'h99999999, 1'b0, 32'h05F5E0FF, 1'b0, 33};
        vecs[3] = '{32'h00000000, 1'b1, 32'h00000000, 1'b0, 33};
        vecs[4] = '{32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 33};
        vecs[5] = '{32'h12345A78, 1'b0, 32'h00000000, 1'b1, 1};
        vecs[6] = '{32'h10000000, 1'b0, 32'h00989680, 1'b0, 33};
        vecs[7] = '{32'hF0000000, 1'b1, 32'h00000000, 1'b1, 1};

        reset = 1'b1;
        start = 1'b0;
        neg   = 1'b0;
        for (int i = 0; i < 8; i++) dv[i] = 4'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset numero", numero, 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        for (int v = 0; v < 8; v++) begin
            convert($sformatf("vec%0d", v), vecs[v].bcd, vecs[v].sgn,
                    vecs[v].exp_num, vecs[v].exp_err, vecs[v].lat);
            @(negedge clock);
            chk($sformatf("vec%0d done pulse", v), 32'(done), 32'd0);
        end

        // Back-to-back: second start lands on the done cycle
        convert("b2b first", 32'h00004321, 1'b0, 32'd4321, 1'b0, 33);
        convert("b2b second", 32'h87654321, 1'b1, 32'(-87654321), 1'b0, 33);
        @(negedge clock);

        // Start while busy is ignored and not queued
        launch(32'h12345678, 1'b0);
        repeat (4) @(posedge clock);
        #1;
        for (int i = 0; i < 8; i++) dv[i] = 4'd9;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        wait_done(cyc, ok);
        chk("repulse done seen", 32'(ok), 32'd1);
        chk("repulse numero", numero, 32'h00BC614E);
        dcount = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) dcount++;
        end
        chk("repulse not queued", 32'(dcount), 32'd0);

        // Reset mid-conversion aborts with no done
        launch(32'h00000777, 1'b0);
        repeat (9) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort numero", numero, 32'd0);
        chk("abort done", 32'(done), 32'd0);
        dcount = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) dcount++;
        end
        chk("abort no done", 32'(dcount), 32'd0);

        // Random conversions against the decimal model
        for (int r = 0; r < 60; r++) begin
            for (int i = 0; i < 8; i++) begin
                logic [3:0] nib;
                nib = 4'($urandom_range(0, 9));
                bcd[4*i +: 4] = nib;
            end
            if ($urandom_range(0, 7) == 0) bcd[4*$urandom_range(0, 7) +: 4] = 4'($urandom_range(10, 15));
            sgn = 1'($urandom);
            model(bcd, sgn, enum_, eerr);
            convert($sformatf("rnd%0d", r), bcd, sgn, enum_, eerr, eerr ? 1 : 33);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
